// File: rtl/playback_note_scheduler.sv
// Playback sequencer: scans note-storage entries against a per-pass time snapshot
// and publishes which keys are sounding, with on/off edge pulses per update.
module playback_note_scheduler #(
    parameter int ADDR_WIDTH  = 7,
    parameter int DEPTH       = 101,
    parameter int NUM_NOTES   = 24,
    parameter int ID_WIDTH    = 5,
    parameter int TIME_WIDTH  = 29,
    parameter int ENTRY_WIDTH = ID_WIDTH + 2 * TIME_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   startPlayback,
    input  logic                   stopPlayback,
    input  logic [TIME_WIDTH-1:0]  microSecondCounter,
    output logic                   resetTimer,
    output logic                   memRequest,
    input  logic                   memGrant,
    output logic [ADDR_WIDTH-1:0]  noteReadAddress,
    input  logic [ENTRY_WIDTH-1:0] retrievedNoteData,
    output logic [NUM_NOTES-1:0]   activeNotes,
    output logic [NUM_NOTES-1:0]   noteOnPulse,
    output logic [NUM_NOTES-1:0]   noteOffPulse,
    output logic                   eventValid,
    output logic                   busy,
    output logic                   donePulse
);

    typedef enum logic [2:0] {
        IDLE, CLRTIME, SNAP, ISSUE, WAIT, EVAL, PUBLISH, DONE
    } stateType;

    stateType state, nextState;

    logic [TIME_WIDTH-1:0] timeSnap;
    logic [NUM_NOTES-1:0]  nextActive;
    logic                  allFinished;
    logic                  sawEntry;

    logic [ID_WIDTH-1:0]   entryId;
    logic [TIME_WIDTH-1:0] entryStart;
    logic [TIME_WIDTH-1:0] entryEnd;
    logic                  entryEmpty;
    logic                  entrySounding;
    logic                  entryOpen;
    logic                  lastAddr;
    logic [NUM_NOTES-1:0]  idMask;
    logic                  stopNow;

    always_comb begin
        entryId       = retrievedNoteData[ENTRY_WIDTH-1 -: ID_WIDTH];
        entryStart    = retrievedNoteData[2*TIME_WIDTH-1 -: TIME_WIDTH];
        entryEnd      = retrievedNoteData[TIME_WIDTH-1:0];
        entryEmpty    = (entryStart == '0) && (entryEnd == '0);
        entryOpen     = (entryEnd == '0) || (entryEnd > timeSnap);
        entrySounding = (entryStart <= timeSnap) && entryOpen;
        lastAddr      = (noteReadAddress == ADDR_WIDTH'(DEPTH - 1));
        idMask        = '0;
        // Ids beyond the keyboard range are stored but never sound.
        if (int'(entryId) < NUM_NOTES)
            idMask = {{(NUM_NOTES-1){1'b0}}, 1'b1} << entryId;
        stopNow       = stopPlayback && (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= nextState;
    end

    always_comb begin
        nextState = state;
        if (stopNow) begin
            nextState = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (startPlayback) nextState = CLRTIME;
                CLRTIME: nextState = SNAP;
                SNAP:    nextState = ISSUE;
                ISSUE:   if (memGrant) nextState = WAIT;
                WAIT:    nextState = memGrant ? EVAL : ISSUE;
                EVAL:    nextState = (entryEmpty || lastAddr) ? PUBLISH : ISSUE;
                PUBLISH: nextState = (allFinished || !sawEntry) ? DONE : SNAP;
                DONE:    nextState = IDLE;
                default: nextState = IDLE;
            endcase
        end
    end

    always_comb begin
        resetTimer = (state == CLRTIME);
        memRequest = ((state == ISSUE) || (state == WAIT)) && !stopPlayback;
        busy       = (state != IDLE);
    end

    // The read address register doubles as the scan pointer, so it holds on stop.
    always_ff @(posedge clk) begin
        if (reset) begin
            timeSnap        <= '0;
            nextActive      <= '0;
            allFinished     <= 1'b0;
            sawEntry        <= 1'b0;
            noteReadAddress <= '0;
            activeNotes     <= '0;
            noteOnPulse     <= '0;
            noteOffPulse    <= '0;
            eventValid      <= 1'b0;
            donePulse       <= 1'b0;
        end else begin
            noteOnPulse  <= '0;
            noteOffPulse <= '0;
            eventValid   <= 1'b0;
            donePulse    <= 1'b0;
            if (stopNow) begin
                activeNotes  <= '0;
                noteOffPulse <= activeNotes;
                eventValid   <= |activeNotes;
            end else begin
                case (state)
                    SNAP: begin
                        timeSnap        <= microSecondCounter;
                        noteReadAddress <= '0;
                        nextActive      <= '0;
                        allFinished     <= 1'b1;
                        sawEntry        <= 1'b0;
                    end
                    EVAL: begin
                        if (!entryEmpty) begin
                            sawEntry <= 1'b1;
                            if (entrySounding)
                                nextActive <= nextActive | idMask;
                            if (entryOpen)
                                allFinished <= 1'b0;
                            if (!lastAddr)
                                noteReadAddress <= noteReadAddress + 1'b1;
                        end
                    end
                    PUBLISH: begin
                        activeNotes  <= nextActive;
                        noteOnPulse  <= nextActive & ~activeNotes;
                        noteOffPulse <= activeNotes & ~nextActive;
                        eventValid   <= 1'b1;
                    end
                    DONE: begin
                        donePulse    <= 1'b1;
                        activeNotes  <= '0;
                        noteOffPulse <= activeNotes;
                        eventValid   <= |activeNotes;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/playback_note_scheduler.md
Name: playback_note_scheduler

Overview:
- Sequences playback from the note storage RAM: repeatedly scans stored note entries, compares each entry's start and end timestamps against the microsecond time base, and publishes which of the 24 keys are sounding.
- Sits between the note storage RAM read port, the microsecond timer, and the audio/keyboard-highlight consumers.
- Shares the RAM read port with the recorder through a request/grant handshake.

Parameters:
- ADDR_WIDTH, 7, RAM address width.
- DEPTH, 101, number of entries scanned (addresses 0..DEPTH-1).
- NUM_NOTES, 24, number of keys.
- ID_WIDTH, 5, note-id field width.
- TIME_WIDTH, 29, timestamp width (microseconds).
- ENTRY_WIDTH, ID_WIDTH+2*TIME_WIDTH, entry layout {noteId, startTime, endTime}, with endTime in the LSBs.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- startPlayback  in  1  1-cycle pulse: begin playback from time 0
- stopPlayback  in  1  level or pulse: abort playback
- microSecondCounter  in  TIME_WIDTH  current time base
- resetTimer  out  1  1-cycle pulse that clears the time base
- memRequest  out  1  scheduler wants the RAM read port
- memGrant  in  1  read port granted (recorder has priority)
- noteReadAddress  out  ADDR_WIDTH  RAM read address
- retrievedNoteData  in  ENTRY_WIDTH  RAM read data, valid 2 cycles after the address is driven
- activeNotes  out  NUM_NOTES  keys currently sounding
- noteOnPulse  out  NUM_NOTES  keys that started sounding this update
- noteOffPulse  out  NUM_NOTES  keys that stopped sounding this update
- eventValid  out  1  1-cycle strobe qualifying the pulse vectors
- busy  out  1  high in every state except IDLE
- donePulse  out  1  1-cycle strobe marking the end of the song

Behaviour:
- Reset:
  - State goes to IDLE.
  - All outputs go to 0, including noteReadAddress, activeNotes, the pulse vectors and memRequest.
  - Internal address, accumulator and snapshot registers clear.
  - Reset wins over every other input on the same cycle.
- States: IDLE, CLRTIME, SNAP, ISSUE, WAIT, EVAL, PUBLISH, DONE.
- IDLE:
  - memRequest=0.
  - startPlayback moves to CLRTIME. Other inputs are ignored.
- CLRTIME:
  - resetTimer=1 for exactly this one cycle, then go to SNAP.
- SNAP:
  - Latch timeSnap = microSecondCounter.
  - Clear address, nextActive and counters; set allFinished=1, sawEntry=0.
  - Go to ISSUE. Every entry in one pass uses the same timeSnap.
- ISSUE:
  - memRequest=1.
  - If memGrant=1: drive noteReadAddress=addr and go to WAIT.
  - If memGrant=0: stay in ISSUE and hold addr.
- WAIT:
  - One cycle, then go to EVAL.
  - If memGrant drops during WAIT, return to ISSUE with the same addr; that read is discarded.
- EVAL: retrievedNoteData is valid here. Decode id, start (s) and end (e) from the entry.
  - Empty entry (s==0 and e==0): end the pass and go to PUBLISH.
  - Otherwise set sawEntry=1.
  - Sounding when s<=timeSnap and (e==0 or timeSnap<e). For a sounding entry with id<NUM_NOTES, set nextActive[id]; ids >= NUM_NOTES are ignored.
  - If e==0 or e>timeSnap, clear allFinished.
  - If addr==DEPTH-1, go to PUBLISH. Otherwise addr+1 and go to ISSUE.
- Comparisons are unsigned, full TIME_WIDTH. There is no time-base wrap handling; playback longer than 2^TIME_WIDTH us is out of scope.
- Throughput: 3 cycles per entry when memGrant is held high.
- PUBLISH (1 cycle):
  - memRequest=0.
  - activeNotes <= nextActive.
  - noteOnPulse <= nextActive & ~activeNotes; noteOffPulse <= activeNotes & ~nextActive.
  - eventValid=1 this cycle, even when both pulse vectors are zero.
  - If (allFinished and sawEntry) or !sawEntry, go to DONE; else go to SNAP (next pass).
- DONE:
  - donePulse=1 for one cycle.
  - Clear activeNotes. Any key still set has its bit in noteOffPulse with eventValid=1 on the same cycle.
  - Go to IDLE.
- stopPlayback=1 in any non-IDLE state:
  - Next state is IDLE.
  - activeNotes is cleared; noteOffPulse = previous activeNotes, eventValid=1 if any bit is set.
  - memRequest=0 and noteReadAddress holds.
  - stopPlayback takes priority over startPlayback and over any pending transition.
- startPlayback while busy is ignored.
- Outside PUBLISH, DONE and the stop cycle, noteOnPulse, noteOffPulse, eventValid and donePulse are 0.

Test Plan:
- Empty RAM (entry 0 all zero), startPlayback -> resetTimer pulse 1 cycle later; one PUBLISH with eventValid=1 and zero vectors; donePulse; busy falls. Total at most 8 cycles, memGrant=1.
- Entry0={id 3, s=100, e=500}, entry1 empty; time held at 50, then 200, then 600 ->
  - at 50: activeNotes=0;
  - at 200: noteOnPulse[3]=1, activeNotes=0x000008;
  - at 600: noteOffPulse[3]=1 then donePulse.
- Entry0={id 23, s=10, e=0} (still recording), time 1000 for 3 passes -> bit 23 active; noteOnPulse only on the first pass; no donePulse.
- memGrant toggles low during WAIT at addr 5 -> ISSUE repeats addr 5; the final activeNotes matches a run with memGrant tied high.
- Two entries id 7 active, stopPlayback mid-pass -> next cycle IDLE, noteOffPulse[7]=1, eventValid=1, activeNotes=0, memRequest=0.
- reset asserted during EVAL -> all outputs 0 next cycle; a subsequent startPlayback runs normally.
